// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the add/and/xor ALU: buffers commands in a small FIFO,
// issues one at a time, waits for done or timeout, and returns a status-tagged response.
module alu_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [1:0]  rsp_status,
    output logic        busy
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_ILLEGAL = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_GAP} state_t;

    state_t         state_reg;
    logic [18:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [7:0]     timer_reg;
    logic [18:0]    head;
    logic           push;
    logic           pop;
    logic           head_legal;

    // Ready depends on the registered count only, so a pop never frees a slot in the same cycle.
    assign cmd_ready  = (count_reg != CW'(FIFO_DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state_reg == ST_IDLE) && (count_reg != '0);
    assign head       = fifo_mem[rd_ptr_reg];
    assign head_legal = (head[2:0] == 3'b001) || (head[2:0] == 3'b010) || (head[2:0] == 3'b011);
    assign busy       = (state_reg != ST_IDLE) || (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_status <= '0;
            timer_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        // Illegal op-codes are answered locally and never reach the ALU.
                        if (head_legal) begin
                            alu_a     <= head[18:11];
                            alu_b     <= head[10:3];
                            alu_op    <= head[2:0];
                            alu_start <= 1'b1;
                            timer_reg <= '0;
                            state_reg <= ST_WAIT;
                        end else begin
                            rsp_result <= '0;
                            rsp_status <= STATUS_ILLEGAL;
                            rsp_valid  <= 1'b1;
                            state_reg  <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    timer_reg <= timer_reg + 8'd1;
                    if (alu_done) begin
                        rsp_result <= alu_result;
                        rsp_status <= STATUS_OK;
                        rsp_valid  <= 1'b1;
                        alu_start  <= 1'b0;
                        state_reg  <= ST_RESP;
                    end else if (timer_reg == 8'(TIMEOUT - 1)) begin
                        rsp_result <= '0;
                        rsp_status <= STATUS_TIMEOUT;
                        rsp_valid  <= 1'b1;
                        alu_start  <= 1'b0;
                        state_reg  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= ST_GAP;
                    end
                end
                default: begin
                    // One quiet cycle lets the ALU's start/done history clear.
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU whose done latency is programmable.
module tb_alu_cmd_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_status;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int done_delay = 0;
    int cyc = 0;
    bit start_seen = 1'b0;

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_status (rsp_status),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ALU model: done is sampled on the done_delay-th rising edge after start rose (0 = never).
    always @(negedge clk) begin
        if (!reset_n || !alu_start) begin
            cyc = 0;
            alu_done = 1'b0;
        end else begin
            start_seen = 1'b1;
            cyc++;
            if (done_delay != 0 && cyc == done_delay) begin
                alu_done = 1'b1;
                case (alu_op)
                    3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
                    3'b010:  alu_result = {8'h00, alu_a & alu_b};
                    3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
                    default: alu_result = 16'hDEAD;
                endcase
            end else begin
                alu_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bit ok = 1'b0;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        if (ok) step(1);
        else check("push_accept", 16'(ok), 16'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input logic [15:0] exp_res, input logic [1:0] exp_st, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            step(1);
        end
        check({tag, "_valid"}, 16'(got), 16'd1);
        if (got) begin
            check({tag, "_result"}, rsp_result, exp_res);
            check({tag, "_status"}, 16'(rsp_status), 16'(exp_st));
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        check({tag, "_consumed"}, 16'(rsp_valid), 16'd0);
    endtask

    initial begin
        int start_cycles;
        bit got;
        bit saw_rsp;
        bit saw_busy;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        check("rst_cmd_ready", 16'(cmd_ready), 16'd1);
        check("rst_alu_start", 16'(alu_start), 16'd0);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_alu_a", 16'(alu_a), 16'd0);
        check("rst_rsp_status", 16'(rsp_status), 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        step(1);

        // Single add, done two cycles after start
        done_delay = 2;
        push(8'hFF, 8'h01, 3'b001);
        step(1);
        check("add_start", 16'(alu_start), 16'd1);
        check("add_alu_a", 16'(alu_a), 16'h00FF);
        check("add_alu_b", 16'(alu_b), 16'h0001);
        check("add_alu_op", 16'(alu_op), 16'd1);
        check("add_busy", 16'(busy), 16'd1);
        step(1);
        check("add_still_waiting", 16'(rsp_valid), 16'd0);
        step(1);
        check("add_rsp_after_done", 16'(rsp_valid), 16'd1);
        check("add_start_dropped", 16'(alu_start), 16'd0);
        collect(16'h0100, 2'b00, "add");
        step(2);

        // Illegal op never reaches the ALU
        start_seen = 1'b0;
        push(8'h12, 8'h34, 3'b111);
        step(1);
        check("ill_rsp_valid", 16'(rsp_valid), 16'd1);
        check("ill_alu_start", 16'(alu_start), 16'd0);
        check("ill_alu_a_kept", 16'(alu_a), 16'h00FF);
        check("ill_alu_op_kept", 16'(alu_op), 16'd1);
        collect(16'h0000, 2'b01, "illegal");
        check("ill_no_start", 16'(start_seen), 16'd0);
        step(2);

        // Timeout: ALU never answers
        done_delay = 0;
        push(8'h03, 8'h04, 3'b001);
        step(1);
        start_cycles = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (alu_start) start_cycles++;
            step(1);
        end
        check("to_rsp_seen", 16'(got), 16'd1);
        check("to_start_cycles", 16'(start_cycles), 16'd15);
        check("to_start_dropped", 16'(alu_start), 16'd0);
        collect(16'h0000, 2'b10, "timeout");
        done_delay = 1;
        push(8'h05, 8'h06, 3'b011);
        collect(16'h0003, 2'b00, "after_to");
        step(2);

        // Back-pressure: fill the FIFO while the first response is held
        done_delay = 1;
        push(8'h0F, 8'hF0, 3'b010);
        push(8'hAA, 8'h55, 3'b011);
        push(8'h80, 8'h80, 3'b001);
        push(8'hFF, 8'h3C, 3'b010);
        push(8'h12, 8'h12, 3'b011);
        check("bp_full", 16'(cmd_ready), 16'd0);
        cmd_a = 8'h01;
        cmd_b = 8'h02;
        cmd_op = 3'b001;
        cmd_valid = 1'b1;
        step(3);
        check("bp_still_full", 16'(cmd_ready), 16'd0);
        collect(16'h0000, 2'b00, "bp_and");
        check("bp_full_gap", 16'(cmd_ready), 16'd0);
        step(1);
        check("bp_full_at_pop", 16'(cmd_ready), 16'd0);
        step(1);
        check("bp_slot_freed", 16'(cmd_ready), 16'd1);
        step(1);
        cmd_valid = 1'b0;
        collect(16'h00FF, 2'b00, "bp_xor");
        collect(16'h0100, 2'b00, "bp_add");
        collect(16'h003C, 2'b00, "bp_and2");
        collect(16'h0000, 2'b00, "bp_xor2");
        collect(16'h0003, 2'b00, "bp_add2");
        step(2);

        // Done arrives on the exact timeout cycle
        done_delay = 15;
        push(8'h10, 8'h20, 3'b001);
        collect(16'h0030, 2'b00, "done_at_to");
        step(2);

        // Reset in the middle of WAIT with three commands queued
        done_delay = 0;
        push(8'h01, 8'h01, 3'b001);
        push(8'h02, 8'h02, 3'b001);
        push(8'h03, 8'h03, 3'b001);
        push(8'h04, 8'h04, 3'b001);
        check("mr_busy", 16'(busy), 16'd1);
        check("mr_start", 16'(alu_start), 16'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mr_alu_start", 16'(alu_start), 16'd0);
        check("mr_busy_cleared", 16'(busy), 16'd0);
        check("mr_cmd_ready", 16'(cmd_ready), 16'd1);
        check("mr_rsp_valid", 16'(rsp_valid), 16'd0);
        check("mr_alu_a", 16'(alu_a), 16'd0);
        check("mr_alu_op", 16'(alu_op), 16'd0);
        check("mr_rsp_result", rsp_result, 16'd0);
        @(negedge clk) reset_n = 1'b1;
        step(1);
        saw_rsp = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) saw_rsp = 1'b1;
            if (busy) saw_busy = 1'b1;
            step(1);
        end
        check("mr_no_response", 16'(saw_rsp), 16'd0);
        check("mr_fifo_empty", 16'(saw_busy), 16'd0);
        done_delay = 1;
        push(8'h07, 8'h0F, 3'b010);
        collect(16'h0007, 2'b00, "mr_fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream command stage for the single-cycle add/and/xor ALU. Buffers operand/op-code commands in a small FIFO and issues them one at a time to the ALU. It holds `start` until the ALU's `done` pulse or a timeout, then returns the result with a status on a valid/ready response port. It also filters illegal op-codes so they never reach the ALU.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- TIMEOUT, 15, max WAIT cycles before abort; range 2..255
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_op  in  3  op-code: 001 add, 010 and, 011 xor; all others illegal
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_op  out  3  registered op-code to ALU
- alu_start  out  1  registered start, held until done/timeout
- alu_done  in  1  ALU completion pulse
- alu_result  in  16  ALU result, valid with alu_done
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_result  out  16  result; 0 on error
- rsp_status  out  2  00 ok, 01 illegal op, 10 timeout
- busy  out  1  high whenever state ≠ IDLE or FIFO non-empty

## Operation
- Reset values: every output 0, except cmd_ready = 1. FIFO empty, state IDLE, timeout counter 0.
- FIFO:
  - Push on cmd_valid & cmd_ready. cmd_ready = !full, computed from the registered count only.
  - A same-cycle pop does not free a slot for that cycle's push.
  - Push + pop in the same cycle on a non-empty FIFO leaves the count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, WAIT, RESP, GAP.
- IDLE, FIFO non-empty: pop the head.
  - Legal op: load alu_a/alu_b/alu_op, set alu_start = 1, clear the counter, go to WAIT.
  - Illegal op: nothing is driven to the ALU. Load rsp_result = 0, rsp_status = 01, rsp_valid = 1, go to RESP.
- WAIT: counter increments each cycle.
  - alu_done = 1: capture alu_result into rsp_result, set rsp_status = 00, rsp_valid = 1, alu_start = 0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT−1: rsp_result = 0, rsp_status = 10, rsp_valid = 1, alu_start = 0, go to RESP.
  - alu_done takes priority over timeout in the same cycle.
- RESP: rsp_valid, rsp_result and rsp_status are held stable until rsp_ready. On rsp_valid & rsp_ready, clear rsp_valid and go to GAP.
- GAP: exactly one cycle with alu_start = 0, so the ALU's start/done history clears. Then go to IDLE.
- alu_done is ignored in every state except WAIT.
- alu_a/alu_b/alu_op retain their last issued values until the next issue.
- Only one command is outstanding at a time. Responses are returned in command order.
- Reset asserted mid-operation: immediate return to reset values. The FIFO contents and any in-flight command are discarded; no response is produced for them.

## Timing
- Command accepted at edge N into an empty FIFO while in IDLE:
  - Popped at edge N+1, with alu_start high after edge N+1.
  - alu_done seen at edge M gives rsp_valid high after edge M.
- Back-to-back commands: the minimum issue-to-issue spacing is WAIT duration + 1 (RESP with rsp_ready already high) + 1 (GAP) + 1 (IDLE).
- Illegal op: rsp_valid is high one cycle after the pop edge. The ALU sees no start.
- Timeout: the abort response appears TIMEOUT cycles after alu_start rose.
- cmd_ready falls the cycle after the FIFO_DEPTH-th unpopped push.

## Test plan
- Single add: A = 0xFF, B = 0x01, op = 001; the ALU model gives done 2 cycles after start. Required: rsp_result = 0x0100, status 00, alu_start low the cycle after done.
- Illegal op 111 with A = 0x12, B = 0x34. Required: alu_start never rises; response has result 0x0000, status 01, one cycle after the pop.
- Timeout: the ALU model never asserts done. Required: after 15 cycles of start, alu_start drops, response is result 0, status 10, and the next command issues normally.
- Full/back-pressure: rsp_ready held 0 while 6 commands are pushed (and 0x0F/0xF0, xor 0xAA/0x55, …).
  - Required: cmd_ready low after the FIFO fills and stays low until the first response pops.
  - Required: all responses in order — and = 0x0000, xor = 0x00FF.
- Simultaneous events: push on the same cycle as a pop at full, and alu_done on the exact timeout cycle. Required: push rejected; status 00 with the captured result.
- Reset mid-WAIT with 3 commands queued. Required: all outputs return to reset values asynchronously, no response emitted, and the FIFO is empty after release.
